// File: rtl/stream_downsizer.sv
// stream_downsizer
//   Splits each IN_W-bit AXI-Stream word into IN_W/OUT_W narrow sub-beats,
//   least-significant slice first. TLAST is carried onto the final sub-beat
//   of the word. One word is held while it drains and one more can be
//   prefetched, so back-to-back wide words stream with no bubble.
//
// Ports
//   AXIS_ACLK, AXIS_ARESETN     clock, synchronous active-low reset
//   S_AXIS_TVALID/TREADY        wide input handshake
//   S_AXIS_TDATA/TLAST          wide word and its frame-end flag
//   M_AXIS_TVALID/TREADY        narrow output handshake
//   M_AXIS_TDATA/TSTRB/TLAST    sub-beat data, all-ones strobe, frame end
//   beat_count                  output handshakes since reset (wraps)
//   frame_done                  one-cycle pulse after the TLAST sub-beat
module stream_downsizer #(
    parameter int unsigned IN_W  = 1024,
    parameter int unsigned OUT_W = 64
) (
    input  logic               AXIS_ACLK,
    input  logic               AXIS_ARESETN,
    input  logic               S_AXIS_TVALID,
    output logic               S_AXIS_TREADY,
    input  logic [IN_W-1:0]    S_AXIS_TDATA,
    input  logic               S_AXIS_TLAST,
    output logic               M_AXIS_TVALID,
    input  logic               M_AXIS_TREADY,
    output logic [OUT_W-1:0]   M_AXIS_TDATA,
    output logic [OUT_W/8-1:0] M_AXIS_TSTRB,
    output logic               M_AXIS_TLAST,
    output logic [31:0]        beat_count,
    output logic               frame_done
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Occupancy: EMPTY = nothing held, DRAIN = hold only, FULL = hold + prefetch.
    typedef enum logic [1:0] {
        EMPTY,
        DRAIN,
        FULL
    } state_t;

    state_t state, state_n;

    logic [RATIO-1:0][OUT_W-1:0] hold_data;
    logic [RATIO-1:0][OUT_W-1:0] pf_data;
    logic                        hold_last;
    logic                        pf_last;
    logic [IDX_W-1:0]            idx;

    logic hold_valid;
    logic out_hs;
    logic in_hs;
    logic word_done;
    logic load_hold_in;
    logic load_hold_pf;
    logic load_pf;

    assign hold_valid    = (state != EMPTY);
    // Ready comes from registered occupancy only; no path from M_AXIS_TREADY.
    assign S_AXIS_TREADY = (state != FULL);
    assign M_AXIS_TVALID = hold_valid;
    assign M_AXIS_TDATA  = hold_data[idx];
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = hold_valid & hold_last & (idx == LAST_IDX);

    assign out_hs    = M_AXIS_TVALID & M_AXIS_TREADY;
    assign in_hs     = S_AXIS_TVALID & S_AXIS_TREADY;
    assign word_done = out_hs & (idx == LAST_IDX);

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Refill order at word-done: prefetch first, then a same-cycle input word.
    always_comb begin
        state_n      = state;
        load_hold_in = 1'b0;
        load_hold_pf = 1'b0;
        load_pf      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_hs) begin
                    load_hold_in = 1'b1;
                    state_n      = DRAIN;
                end
            end
            DRAIN: begin
                if (word_done) begin
                    if (in_hs) begin
                        load_hold_in = 1'b1;
                    end else begin
                        state_n = EMPTY;
                    end
                end else if (in_hs) begin
                    load_pf = 1'b1;
                    state_n = FULL;
                end
            end
            FULL: begin
                if (word_done) begin
                    load_hold_pf = 1'b1;
                    state_n      = DRAIN;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Data registers carry no reset; the valid state qualifies them.
    always_ff @(posedge AXIS_ACLK) begin
        if (load_hold_in) begin
            hold_data <= S_AXIS_TDATA;
            hold_last <= S_AXIS_TLAST;
        end else if (load_hold_pf) begin
            hold_data <= pf_data;
            hold_last <= pf_last;
        end
        if (load_pf) begin
            pf_data <= S_AXIS_TDATA;
            pf_last <= S_AXIS_TLAST;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            idx        <= '0;
            beat_count <= '0;
            frame_done <= 1'b0;
        end else begin
            if (out_hs) begin
                idx        <= word_done ? '0 : idx + 1'b1;
                beat_count <= beat_count + 32'd1;
            end
            frame_done <= out_hs & M_AXIS_TLAST;
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer
//   Directed bench for stream_downsizer (IN_W=1024, OUT_W=64). A beat-level
//   queue model predicts every output sub-beat, occupancy-derived ready,
//   beat_count and frame_done; a per-cycle compare process checks the DUT
//   against it, and literal expectations pin the model.
module tb_stream_downsizer;

    localparam int unsigned IN_W  = 1024;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned RATIO = IN_W / OUT_W;

    logic               AXIS_ACLK;
    logic               AXIS_ARESETN;
    logic               S_AXIS_TVALID;
    logic               S_AXIS_TREADY;
    logic [IN_W-1:0]    S_AXIS_TDATA;
    logic               S_AXIS_TLAST;
    logic               M_AXIS_TVALID;
    logic               M_AXIS_TREADY;
    logic [OUT_W-1:0]   M_AXIS_TDATA;
    logic [OUT_W/8-1:0] M_AXIS_TSTRB;
    logic               M_AXIS_TLAST;
    logic [31:0]        beat_count;
    logic               frame_done;

    stream_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESETN  (AXIS_ARESETN),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .beat_count    (beat_count),
        .frame_done    (frame_done)
    );

    initial AXIS_ACLK = 1'b0;
    always #5 AXIS_ACLK = ~AXIS_ACLK;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    chk_en   = 1'b0;
    bit    rand_rdy = 1'b0;

    // Model state
    beat_t       exp_q[$];
    logic [31:0] exp_cnt = '0;
    logic        exp_fd  = 1'b0;

    // Observation log
    logic [OUT_W-1:0] obs_d[$];
    logic             obs_l[$];
    int               obs_n    = 0;
    int               pulses   = 0;
    int               run      = 0;
    int               last_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] make_word(input logic [31:0] tag);
        logic [IN_W-1:0] w;
        for (int i = 0; i < int'(RATIO); i++) begin
            w[i*OUT_W +: OUT_W] = {tag, 32'(i)};
        end
        return w;
    endfunction

    // Compare, then advance the model to what the next edge will produce.
    always @(negedge AXIS_ACLK) begin
        int  words;
        bit  m_valid;
        bit  m_hs;
        bit  s_rdy;
        words   = (exp_q.size() + RATIO - 1) / RATIO;
        m_valid = (exp_q.size() != 0);
        s_rdy   = (words < 2);
        if (chk_en) begin
            check("m_tvalid", 64'(M_AXIS_TVALID), 64'(m_valid));
            check("s_tready", 64'(S_AXIS_TREADY), 64'(s_rdy));
            check("beat_count", 64'(beat_count), 64'(exp_cnt));
            check("frame_done", 64'(frame_done), 64'(exp_fd));
            check("m_tstrb", 64'(M_AXIS_TSTRB), 64'(8'hFF));
            if (m_valid) begin
                check("m_tdata", 64'(M_AXIS_TDATA), 64'(exp_q[0].d));
                check("m_tlast", 64'(M_AXIS_TLAST), 64'(exp_q[0].l));
            end else begin
                check("m_tlast_idle", 64'(M_AXIS_TLAST), 64'd0);
            end
            if (frame_done === 1'b1) pulses++;
            if (M_AXIS_TVALID === 1'b1) begin
                run++;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
        end
        if (!AXIS_ARESETN) begin
            exp_q.delete();
            exp_cnt = '0;
            exp_fd  = 1'b0;
        end else begin
            m_hs   = m_valid && (M_AXIS_TREADY === 1'b1);
            exp_fd = 1'b0;
            if (m_hs) begin
                exp_fd = exp_q[0].l;
                obs_d.push_back(M_AXIS_TDATA);
                obs_l.push_back(M_AXIS_TLAST);
                obs_n++;
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 32'd1;
            end
            if (S_AXIS_TVALID && s_rdy) begin
                for (int i = 0; i < int'(RATIO); i++) begin
                    exp_q.push_back('{S_AXIS_TDATA[i*OUT_W +: OUT_W],
                                      S_AXIS_TLAST && (i == int'(RATIO) - 1)});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge AXIS_ACLK);
            #1;
            if (rand_rdy) M_AXIS_TREADY = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_word(input logic [IN_W-1:0] d, input logic l);
        bit got;
        bit done;
        done          = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge AXIS_ACLK);
            got = S_AXIS_TREADY;
            @(posedge AXIS_ACLK);
            #1;
            if (got) done = 1'b1;
        end
        if (!done) check("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle_in();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 10000 && !done; i++) begin
            @(posedge AXIS_ACLK);
            #1;
            if (exp_q.size() == 0 && M_AXIS_TVALID == 1'b0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(posedge AXIS_ACLK);
        #1;
    endtask

    task automatic do_reset();
        AXIS_ARESETN = 1'b0;
        @(posedge AXIS_ACLK);
        #1;
        AXIS_ARESETN = 1'b1;
    endtask

    initial begin
        int base;
        int p0;
        int ones;
        bit done;
        AXIS_ARESETN  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (2) @(posedge AXIS_ACLK);
        #1;
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("rst_tready", 64'(S_AXIS_TREADY), 64'd1);
        check("rst_count", 64'(beat_count), 64'd0);
        check("rst_fdone", 64'(frame_done), 64'd0);
        check("rst_tstrb", 64'(M_AXIS_TSTRB), 64'hFF);
        AXIS_ARESETN = 1'b1;
        chk_en       = 1'b1;

        // Single word with TLAST
        base = obs_n;
        send_word(make_word(32'hA5A5A5A5), 1'b1);
        idle_in();
        wait_drain();
        check("t1_beat0", obs_d[base], 64'hA5A5A5A5_00000000);
        check("t1_beat15", obs_d[base+15], 64'hA5A5A5A5_0000000F);
        check("t1_last15", 64'(obs_l[base+15]), 64'd1);
        check("t1_last14", 64'(obs_l[base+14]), 64'd0);
        check("t1_count", 64'(beat_count), 64'd16);
        check("t1_pulses", 64'(pulses), 64'd1);
        check("t1_run", 64'(last_run), 64'd16);

        // Three back-to-back words
        base = obs_n;
        send_word(make_word(32'h00000001), 1'b0);
        send_word(make_word(32'h00000002), 1'b0);
        send_word(make_word(32'h00000003), 1'b1);
        idle_in();
        wait_drain();
        check("t2_run", 64'(last_run), 64'd48);
        check("t2_count", 64'(beat_count), 64'd64);
        check("t2_last47", 64'(obs_l[base+47]), 64'd1);
        check("t2_last31", 64'(obs_l[base+31]), 64'd0);
        check("t2_beat16", obs_d[base+16], 64'h00000002_00000000);
        check("t2_pulses", 64'(pulses), 64'd2);

        // Word-done coinciding with a new input in DRAIN
        base = obs_n;
        send_word(make_word(32'h0000BEEF), 1'b0);
        idle_in();
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (obs_n >= base + 15) done = 1'b1;
            else begin
                @(posedge AXIS_ACLK);
                #1;
            end
        end
        if (!done) check("t4_timeout", 64'd1, 64'd0);
        check("t4_tready_drain", 64'(S_AXIS_TREADY), 64'd1);
        send_word(make_word(32'h0000CAFE), 1'b1);
        idle_in();
        wait_drain();
        check("t4_run", 64'(last_run), 64'd32);
        check("t4_beat16", obs_d[base+16], 64'h0000CAFE_00000000);

        // Reset mid-frame after 5 sub-beats
        base = obs_n;
        send_word(make_word(32'h0000DEAD), 1'b1);
        idle_in();
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (obs_n >= base + 5) done = 1'b1;
            else begin
                @(posedge AXIS_ACLK);
                #1;
            end
        end
        if (!done) check("t5_timeout", 64'd1, 64'd0);
        p0 = pulses;
        AXIS_ARESETN = 1'b0;
        @(posedge AXIS_ACLK);
        #1;
        check("t5_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("t5_tready", 64'(S_AXIS_TREADY), 64'd1);
        check("t5_count", 64'(beat_count), 64'd0);
        AXIS_ARESETN = 1'b1;
        base = obs_n;
        send_word(make_word(32'h00001234), 1'b1);
        idle_in();
        wait_drain();
        check("t5_fresh0", obs_d[base], 64'h00001234_00000000);
        check("t5_count16", 64'(beat_count), 64'd16);
        check("t5_pulses", 64'(pulses), 64'(p0 + 1));

        // Word without TLAST, then idle
        base = obs_n;
        p0   = pulses;
        send_word(make_word(32'h00005555), 1'b0);
        idle_in();
        wait_drain();
        ones = 0;
        for (int i = base; i < obs_n; i++) ones += int'(obs_l[i]);
        check("t6_beats", 64'(obs_n - base), 64'd16);
        check("t6_nolast", 64'(ones), 64'd0);
        check("t6_pulses", 64'(pulses), 64'(p0));
        check("t6_tvalid", 64'(M_AXIS_TVALID), 64'd0);

        // Random downstream ready over 100 words
        do_reset();
        rand_rdy = 1'b1;
        base     = obs_n;
        for (int w = 0; w < 100; w++) begin
            send_word(make_word(32'(32'h10000 + w)), 1'(w == 99));
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 3)) @(posedge AXIS_ACLK);
                #1;
            end
        end
        idle_in();
        wait_drain();
        rand_rdy      = 1'b0;
        M_AXIS_TREADY = 1'b1;
        @(posedge AXIS_ACLK);
        #1;
        check("t3_count", 64'(beat_count), 64'd1600);
        check("t3_beats", 64'(obs_n - base), 64'd1600);
        check("t3_lastbeat", obs_d[base+1599], 64'h00010063_0000000F);
        check("t3_lastflag", 64'(obs_l[base+1599]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
